// File: rtl/spi_reg_master.sv
// spi_reg_master: mode-0 (CPOL=0, CPHA=0) SPI initiator for single-register frames.
// Each frame is one command byte followed by REG_W data bits, MSB first. Read data returns with a one-cycle pulse.
module spi_reg_master #(
    parameter int ADDR_W = 3,
    parameter int REG_W  = 8,
    parameter int DIV    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [REG_W-1:0]  cmd_wdata,
    output logic              rsp_valid,
    output logic [REG_W-1:0]  rsp_rdata,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    // Handshake: a command transfers on the rising clk edge where cmd_valid && cmd_ready.
    // cmd_ready is high only in IDLE with ena=1. The response has no backpressure; rsp_valid is one cycle wide.

    localparam int N     = 8 + REG_W;
    localparam int CNT_W = $clog2(DIV);
    localparam int BIT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
    localparam logic [BIT_W-1:0] BIT_END  = BIT_W'(N);

    if (ADDR_W < 1 || ADDR_W > 7) begin : g_bad_addr_w
        $error("spi_reg_master: ADDR_W must be 1..7");
    end
    if (REG_W < 1) begin : g_bad_reg_w
        $error("spi_reg_master: REG_W must be at least 1");
    end
    if (DIV < 4) begin : g_bad_div
        $error("spi_reg_master: DIV must be at least 4");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        GAP      = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [N-1:0]     sr_q, sr_d;
    logic             wr_q, wr_d;
    logic             cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic [REG_W-1:0] rdata_q, rdata_d;
    logic             rsp_pend_q, rsp_pend_d;
    logic             miso_meta_q, miso_sync_q;

    logic [7:0]       cmd_byte;
    logic [N-1:0]     frame;
    logic             tick;

    assign cmd_byte = {cmd_write, 7'(cmd_addr)};
    assign frame    = {cmd_byte, (cmd_write ? cmd_wdata : {REG_W{1'b0}})};
    assign tick     = (div_q == DIV_LAST);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        sr_d       = sr_q;
        wr_d       = wr_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        rdata_d    = rdata_q;
        // A pending response is presented only while ena is high, then retired.
        rsp_pend_d = rsp_pend_q & ~ena;

        if (ena) begin
            if (state_q != IDLE) begin
                div_d = tick ? '0 : div_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    div_d = '0;
                    if (cmd_valid) begin
                        state_d = SETUP;
                        sr_d    = frame;
                        wr_d    = cmd_write;
                        bit_d   = '0;
                        cs_n_d  = 1'b0;
                        sclk_d  = 1'b0;
                        mosi_d  = frame[N-1];
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state_d = SHIFT_HI;
                        sclk_d  = 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (div_q == '0) begin
                        sr_d = {sr_q[N-2:0], miso_sync_q};
                    end
                    if (tick) begin
                        state_d = SHIFT_LO;
                        sclk_d  = 1'b0;
                        bit_d   = bit_q + 1'b1;
                        // After the last bit MOSI parks low for the CS hold phase.
                        mosi_d  = (bit_q == BIT_LAST) ? 1'b0 : sr_q[N-1];
                    end
                end
                SHIFT_LO: begin
                    if (tick) begin
                        if (bit_q == BIT_END) begin
                            state_d    = GAP;
                            cs_n_d     = 1'b1;
                            rsp_pend_d = 1'b1;
                            if (!wr_q) begin
                                rdata_d = sr_q[REG_W-1:0];
                            end
                        end else begin
                            state_d = SHIFT_HI;
                            sclk_d  = 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    sclk_d  = 1'b0;
                    mosi_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            sr_q        <= '0;
            wr_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            rdata_q     <= '0;
            rsp_pend_q  <= 1'b0;
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            sr_q        <= sr_d;
            wr_q        <= wr_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            rdata_q     <= rdata_d;
            rsp_pend_q  <= rsp_pend_d;
            miso_meta_q <= spi_miso;
            miso_sync_q <= miso_meta_q;
        end
    end

    assign cmd_ready = ena && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_pend_q & ena;
    assign rsp_rdata = rdata_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_clk   = sclk_q;
    assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// tb_spi_reg_master: directed frames against a behavioural 8-register SPI peripheral model.
// Frame timing is measured in clk cycles relative to the accept cycle T.
module tb_spi_reg_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [2:0] cmd_addr = 3'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       cmd_ready, rsp_valid, busy, spi_cs_n, spi_clk, spi_mosi;
    logic [7:0] rsp_rdata;
    logic       spi_miso = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Per-frame measurements filled in by do_frame
    int          r_acc, r_cs_hi_at, r_rsp_at, r_rsp_cnt, r_ready_at, r_rises, r_hi_max;
    logic        r_cs_lo1;
    logic [15:0] r_mosi;
    logic [7:0]  r_rdata;

    spi_reg_master #(.ADDR_W(3), .REG_W(8), .DIV(4)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral model: samples MOSI on rising SCLK, drives MISO after falling SCLK
    logic [7:0]  pregs [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00};
    int          p_bits = 0;
    logic [15:0] p_sh = 16'h0;
    logic [7:0]  p_cmd = 8'h0;

    always @(posedge spi_clk or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            p_bits = 0;
        end else begin
            p_sh = {p_sh[14:0], spi_mosi};
            p_bits++;
            if (p_bits == 8) p_cmd = p_sh[7:0];
            if (p_bits == 16 && p_cmd[7]) pregs[p_cmd[2:0]] = p_sh[7:0];
        end
    end

    always @(negedge spi_clk) begin
        if (!spi_cs_n && !p_cmd[7] && p_bits >= 8 && p_bits < 16)
            spi_miso = pregs[p_cmd[2:0]][15 - p_bits];
        else
            spi_miso = 1'b0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    // Issues one command and measures the frame until cmd_ready returns.
    // stall_at: relative cycle where ena drops for 10 cycles. hold: keep cmd_valid high.
    task automatic do_frame(input logic wr, input logic [2:0] addr, input logic [7:0] wd,
                            input int stall_at, input bit hold);
        int   rel;
        int   hi_run;
        logic prev_clk;
        rel = 0;
        while (!cmd_ready && rel < 400) begin
            @(negedge clk);
            rel++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        r_acc     = cyc;
        @(negedge clk);
        if (!hold) begin
            cmd_valid = 1'b0;
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = 3'($urandom_range(0, 7));
            cmd_wdata = 8'($urandom_range(0, 255));
        end
        r_rises = 0; r_mosi = 16'h0; r_rsp_cnt = 0; r_rsp_at = -1; r_cs_hi_at = -1;
        r_ready_at = -1; r_hi_max = 0; r_rdata = 8'h0;
        hi_run = 0; prev_clk = 1'b0;
        r_cs_lo1 = spi_cs_n;
        for (rel = 1; rel <= 400; rel++) begin
            if (spi_clk && !prev_clk) begin
                r_rises++;
                r_mosi = {r_mosi[14:0], spi_mosi};
            end
            hi_run = spi_clk ? hi_run + 1 : 0;
            if (hi_run > r_hi_max) r_hi_max = hi_run;
            prev_clk = spi_clk;
            if (spi_cs_n && r_cs_hi_at < 0) r_cs_hi_at = rel;
            if (rsp_valid) begin
                r_rsp_cnt++;
                r_rsp_at = rel;
                r_rdata  = rsp_rdata;
            end
            if (cmd_ready) begin
                r_ready_at = rel;
                break;
            end
            if (rel == stall_at) ena = 1'b0;
            if (rel == stall_at + 10) ena = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b want 1", spi_cs_n); end
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b want 0", spi_clk); end
        checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b want 0", spi_mosi); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h want 00", rsp_rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", cmd_ready); end
        // With ena low a valid command must not be accepted
        ena = 1'b0;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ena_low_ready: got %b want 0", cmd_ready); end
        checks++; if (busy !== 1'b0 || spi_cs_n !== 1'b1) begin
            errors++; $display("FAIL ena_low_accept: busy=%b cs_n=%b want 0/1", busy, spi_cs_n);
        end
        cmd_valid = 1'b0;
        ena = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        do_frame(1'b1, 3'd3, 8'hA5, 1000, 1'b0);
        checks++; if (r_cs_lo1 !== 1'b0) begin errors++; $display("FAIL wr_cs_low_t1: got %b want 0", r_cs_lo1); end
        checks++; if (r_cs_hi_at != 133) begin errors++; $display("FAIL wr_cs_high_at: got %0d want 133", r_cs_hi_at); end
        checks++; if (r_rises != 16) begin errors++; $display("FAIL wr_rises: got %0d want 16", r_rises); end
        checks++; if (r_mosi !== 16'h83A5) begin errors++; $display("FAIL wr_mosi: got %h want 83a5", r_mosi); end
        checks++; if (r_rsp_cnt != 1 || r_rsp_at != 133) begin
            errors++; $display("FAIL wr_rsp: count %0d at %0d want 1 at 133", r_rsp_cnt, r_rsp_at);
        end
        checks++; if (r_ready_at != 137) begin errors++; $display("FAIL wr_ready_at: got %0d want 137", r_ready_at); end
        checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata_held: got %h want 00", rsp_rdata); end
        checks++; if (pregs[3] !== 8'hA5) begin errors++; $display("FAIL wr_periph_reg3: got %h want a5", pregs[3]); end
    endtask

    task automatic test_read();
        do_frame(1'b0, 3'd5, 8'hFF, 1000, 1'b0);
        checks++; if (r_mosi !== 16'h0500) begin errors++; $display("FAIL rd_mosi: got %h want 0500", r_mosi); end
        checks++; if (r_rsp_cnt != 1 || r_rsp_at != 133) begin
            errors++; $display("FAIL rd_rsp: count %0d at %0d want 1 at 133", r_rsp_cnt, r_rsp_at);
        end
        checks++; if (r_rdata !== 8'h3C) begin errors++; $display("FAIL rd_rdata: got %h want 3c", r_rdata); end
        checks++; if (r_ready_at != 137 || busy !== 1'b0) begin
            errors++; $display("FAIL rd_idle: ready_at %0d busy %b want 137/0", r_ready_at, busy);
        end
        repeat (5) @(negedge clk);
        checks++; if (rsp_rdata !== 8'h3C) begin errors++; $display("FAIL rd_rdata_hold: got %h want 3c", rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        int acc [3];
        int cs_hi [3];
        int rsp_total;
        logic [2:0]  addrs [3] = '{3'd0, 3'd6, 3'd7};
        logic [7:0]  datas [3] = '{8'h12, 8'h34, 8'h56};
        logic [15:0] exp_mosi;
        rsp_total = 0;
        for (int i = 0; i < 3; i++) begin
            do_frame(1'b1, addrs[i], datas[i], 1000, 1'b1);
            acc[i]   = r_acc;
            cs_hi[i] = r_cs_hi_at;
            rsp_total += r_rsp_cnt;
            exp_mosi = {5'b10000, addrs[i], datas[i]};
            checks++; if (r_mosi !== exp_mosi) begin
                errors++; $display("FAIL b2b_mosi%0d: got %h want %h", i, r_mosi, exp_mosi);
            end
        end
        cmd_valid = 1'b0;
        checks++; if (rsp_total != 3) begin errors++; $display("FAIL b2b_rsp_count: got %0d want 3", rsp_total); end
        for (int i = 1; i < 3; i++) begin
            // Ready returns DIV cycles after CS rises; the held command is taken that cycle and
            // CS falls the next, so CS stays high for DIV+1 cycles between frames.
            checks++; if (acc[i] - acc[i-1] != 137) begin
                errors++; $display("FAIL b2b_pitch%0d: got %0d want 137", i, acc[i] - acc[i-1]);
            end
            checks++; if (acc[i] - acc[i-1] - cs_hi[i-1] + 1 != 5) begin
                errors++; $display("FAIL b2b_cs_gap%0d: got %0d want 5", i, acc[i] - acc[i-1] - cs_hi[i-1] + 1);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int pulses;
        while (!cmd_ready) @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd2; cmd_wdata = 8'hFF;
        @(negedge clk);
        cmd_valid = 1'b0;
        // Fifth rising SCLK edge lands 1+DIV+8*DIV = 37 cycles after accept
        repeat (36) @(negedge clk);
        checks++; if (spi_clk !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rm_fifth_edge: sclk=%b busy=%b want 1/1", spi_clk, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (spi_cs_n !== 1'b1 || spi_clk !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rm_abort: cs_n=%b sclk=%b busy=%b rsp=%b want 1/0/0/0",
                               spi_cs_n, spi_clk, busy, rsp_valid);
        end
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rm_no_rsp: got %0d pulses want 0", pulses); end
        checks++; if (pregs[2] !== 8'h00) begin errors++; $display("FAIL rm_periph_reg2: got %h want 00", pregs[2]); end
        do_frame(1'b1, 3'd1, 8'h5A, 1000, 1'b0);
        checks++; if (r_mosi !== 16'h815A || r_rsp_at != 133 || r_ready_at != 137) begin
            errors++; $display("FAIL rm_after_write: mosi %h rsp %0d ready %0d want 815a/133/137",
                               r_mosi, r_rsp_at, r_ready_at);
        end
    endtask

    task automatic test_ena_stall();
        // ena drops on cycle 6, inside the first high phase (cycles 5..8)
        do_frame(1'b1, 3'd4, 8'hC3, 6, 1'b0);
        checks++; if (r_hi_max != 14) begin errors++; $display("FAIL st_sclk_high: got %0d want 14", r_hi_max); end
        checks++; if (r_rsp_cnt != 1 || r_rsp_at != 143) begin
            errors++; $display("FAIL st_rsp: count %0d at %0d want 1 at 143", r_rsp_cnt, r_rsp_at);
        end
        checks++; if (r_ready_at != 147) begin errors++; $display("FAIL st_ready_at: got %0d want 147", r_ready_at); end
        checks++; if (r_mosi !== 16'h84C3 || r_rises != 16) begin
            errors++; $display("FAIL st_frame: mosi %h rises %0d want 84c3/16", r_mosi, r_rises);
        end
    endtask

    task automatic test_loopback();
        logic [7:0]  exp_q [$];
        logic [7:0]  exp;
        logic [63:0] cfg;
        for (int i = 0; i < 8; i++) begin
            do_frame(1'b1, 3'(i), 8'(8'h11 * i), 1000, 1'b0);
            exp_q.push_back(8'(8'h11 * i));
        end
        for (int i = 0; i < 8; i++) begin
            do_frame(1'b0, 3'(i), 8'h00, 1000, 1'b0);
            exp = exp_q.pop_front();
            checks++; if (r_rsp_cnt != 1 || r_rdata !== exp) begin
                errors++; $display("FAIL lb_read%0d: got %h (pulses %0d) want %h", i, r_rdata, r_rsp_cnt, exp);
            end
        end
        cfg = {pregs[7], pregs[6], pregs[5], pregs[4], pregs[3], pregs[2], pregs[1], pregs[0]};
        checks++; if (cfg !== 64'h7766554433221100) begin
            errors++; $display("FAIL lb_config_regs: got %h want 7766554433221100", cfg);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_frame();
        test_ena_stall();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
